// File: rtl/reg_wb_pkg.sv
// Shared types and defaults for the register-file writeback controller.
// The optional power-up zero sweep is enabled with REG_WB_INIT_EN.
package reg_wb_pkg;

    localparam int REG_WB_AW = 5;
    localparam int REG_WB_DW = 32;
    localparam int NREGS     = 2 ** REG_WB_AW;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [REG_WB_AW-1:0] addr;
        logic [REG_WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_wb_fifo.sv
// Synchronous FIFO of pending register writes. It exposes its storage, a per-entry
// valid vector and the write pointer so the parent can find the youngest match.
module reg_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              push_addr,
    input  logic [DW-1:0]              push_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)-1:0]   wptr,
    output logic [AW-1:0]              head_addr,
    output logic [DW-1:0]              head_data,
    output logic [AW-1:0]              ent_addr [DEPTH],
    output logic [DW-1:0]              ent_data [DEPTH],
    output logic [DEPTH-1:0]           ent_valid
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wptr_r;
    logic [PW-1:0]    rptr_r;
    logic [PW:0]      count_r;
    logic [DEPTH-1:0] valid_r;
    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (PW+1)'(DEPTH));
    assign empty     = (count_r == {(PW+1){1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign count     = count_r;
    assign wptr      = wptr_r;
    assign head_addr = addr_mem[rptr_r];
    assign head_data = data_mem[rptr_r];
    assign ent_addr  = addr_mem;
    assign ent_data  = data_mem;
    assign ent_valid = valid_r;

    // Pointers, occupancy and per-entry valid flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {(PW+1){1'b0}};
            valid_r <= {DEPTH{1'b0}};
        end else begin
            if (push_ok_s) begin
                wptr_r          <= wptr_r + PW'(1'b1);
                valid_r[wptr_r] <= 1'b1;
            end
            if (pop_ok_s) begin
                rptr_r          <= rptr_r + PW'(1'b1);
                valid_r[rptr_r] <= 1'b0;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PW+1)'(1'b1);
                2'b01:   count_r <= count_r - (PW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents only matter where the valid flag is set.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            addr_mem[wptr_r] <= push_addr;
            data_mem[wptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Writeback-side driver of the register file write port (we3/A3/WD3) with a
// request FIFO and forwarding lookup. REG_WB_INIT_EN adds a zero sweep after reset.
module reg_wb_ctrl
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_WB_AW,
    parameter int DW    = REG_WB_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    output logic          we3,
    output logic [AW-1:0] A3,
    output logic [DW-1:0] WD3,
    input  logic [AW-1:0] fwd_addr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic          busy
);

    localparam int PW = $clog2(DEPTH);

`ifdef REG_WB_INIT_EN
    localparam wb_state_t RST_STATE = ST_INIT;
    logic [AW-1:0] init_cnt_r;
    logic [AW-1:0] init_cnt_next;
`else
    localparam wb_state_t RST_STATE = ST_RUN;
`endif

    wb_state_t        state_r;
    wb_state_t        state_next;
    logic             we3_next;
    logic [AW-1:0]    a3_next;
    logic [DW-1:0]    wd3_next;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [PW:0]      count_s;
    logic [PW-1:0]    wptr_s;
    logic [AW-1:0]    head_addr_s;
    logic [DW-1:0]    head_data_s;
    logic [AW-1:0]    ent_addr_s [DEPTH];
    logic [DW-1:0]    ent_data_s [DEPTH];
    logic [DEPTH-1:0] ent_valid_s;

    reg_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_addr (in_addr),
        .push_data (in_data),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s),
        .wptr      (wptr_s),
        .head_addr (head_addr_s),
        .head_data (head_data_s),
        .ent_addr  (ent_addr_s),
        .ent_data  (ent_data_s),
        .ent_valid (ent_valid_s)
    );

    // in_ready depends only on registered occupancy, so a same-edge pop never frees a full FIFO.
    assign in_ready = ~rst & (state_r == ST_RUN) & ~full_s;
    assign push_s   = in_valid & in_ready & (in_addr != {AW{1'b0}});
    assign busy     = rst | (state_r == ST_INIT) | (count_s != {(PW+1){1'b0}}) | we3;

    // Next-state and next write-port values.
    always_comb begin
        state_next = state_r;
        we3_next   = 1'b0;
        a3_next    = A3;
        wd3_next   = WD3;
        pop_s      = 1'b0;
`ifdef REG_WB_INIT_EN
        init_cnt_next = init_cnt_r;
`endif
        case (state_r)
            ST_INIT: begin
`ifdef REG_WB_INIT_EN
                // Counter wraps to zero once the top register has been issued.
                if (init_cnt_r == {AW{1'b0}}) begin
                    state_next = ST_RUN;
                end else begin
                    we3_next      = 1'b1;
                    a3_next       = init_cnt_r;
                    wd3_next      = {DW{1'b0}};
                    init_cnt_next = init_cnt_r + AW'(1'b1);
                end
`else
                state_next = ST_RUN;
`endif
            end
            ST_RUN: begin
                if (!empty_s) begin
                    pop_s    = 1'b1;
                    we3_next = 1'b1;
                    a3_next  = head_addr_s;
                    wd3_next = head_data_s;
                end else begin
                    we3_next = 1'b0;
                end
            end
            default: begin
                state_next = RST_STATE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RST_STATE;
        end else begin
            state_r <= state_next;
        end
    end

`ifdef REG_WB_INIT_EN
    // Zero-sweep address counter, starting at register 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt_r <= AW'(1'b1);
        end else begin
            init_cnt_r <= init_cnt_next;
        end
    end
`endif

    // Registered register-file write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3 <= 1'b0;
            A3  <= {AW{1'b0}};
            WD3 <= {DW{1'b0}};
        end else begin
            we3 <= we3_next;
            A3  <= a3_next;
            WD3 <= wd3_next;
        end
    end

    // Youngest pending match: walk back from the tail, then the output register.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        found    = 1'b0;
        idx      = {PW{1'b0}};
        fwd_data = {DW{1'b0}};
        if ((state_r == ST_RUN) && (fwd_addr != {AW{1'b0}})) begin
            for (int i = 1; i <= DEPTH; i++) begin
                idx = wptr_s - PW'(i);
                if (!found && ent_valid_s[idx] && (ent_addr_s[idx] == fwd_addr)) begin
                    found    = 1'b1;
                    fwd_data = ent_data_s[idx];
                end
            end
            if (!found && we3 && (A3 == fwd_addr)) begin
                found    = 1'b1;
                fwd_data = WD3;
            end
        end else begin
            found = 1'b0;
        end
        fwd_hit = found;
    end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Randomized and directed bench for reg_wb_ctrl against a queue-based model;
// follows the REG_WB_INIT_EN setting of the build.
module tb_reg_wb_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NREGS = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          we3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Model: pending writes in acceptance order plus the visible write port.
    logic [AW+DW-1:0] mq [$];
    logic             m_we;
    logic [AW-1:0]    m_a;
    logic [DW-1:0]    m_d;
    bit               m_init;
    int               m_cnt;

    reg_wb_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .we3      (we3),
        .A3       (A3),
        .WD3      (WD3),
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0;
        m_a  = '0;
        m_d  = '0;
`ifdef REG_WB_INIT_EN
        m_init = 1'b1;
        m_cnt  = 1;
`else
        m_init = 1'b0;
        m_cnt  = 0;
`endif
    endtask

    task automatic model_fwd(input logic [AW-1:0] fa, output logic hit, output logic [DW-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (!m_init && fa != '0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!hit && mq[i][AW+DW-1:DW] == fa) begin
                    hit  = 1'b1;
                    data = mq[i][DW-1:0];
                end
            end
            if (!hit && m_we && m_a == fa) begin
                hit  = 1'b1;
                data = m_d;
            end
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [AW-1:0] fa, output logic acc);
        logic          e_hit;
        logic [DW-1:0] e_data;
        logic          e_rdy;
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        fwd_addr = fa;
        #1;
        e_rdy = !m_init && (mq.size() < DEPTH);
        model_fwd(fa, e_hit, e_data);
        check_val("in_ready", in_ready, e_rdy);
        check_val("we3", we3, m_we);
        check_val("A3", A3, m_a);
        check_val("WD3", WD3, m_d);
        check_val("busy", busy, m_init || mq.size() > 0 || m_we);
        check_val("fwd_hit", fwd_hit, e_hit);
        check_val("fwd_data", fwd_data, e_data);
        acc = v && e_rdy;
        @(posedge clk);
        if (m_init) begin
            if (m_cnt == NREGS) begin
                m_init = 1'b0;
                m_we   = 1'b0;
            end else begin
                m_we = 1'b1;
                m_a  = AW'(m_cnt);
                m_d  = '0;
                m_cnt++;
            end
        end else if (mq.size() > 0) begin
            m_we = 1'b1;
            {m_a, m_d} = mq.pop_front();
        end else begin
            m_we = 1'b0;
        end
        if (acc && a != '0) mq.push_back({a, d});
        @(negedge clk);
    endtask

    initial begin
        logic          acc;
        logic          hv;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        fwd_addr = '0;
        model_reset();

        #12;
        check_val("rst_we3", we3, 1'b0);
        check_val("rst_A3", A3, '0);
        check_val("rst_WD3", WD3, '0);
        check_val("rst_in_ready", in_ready, 1'b0);
        check_val("rst_busy", busy, 1'b1);
        @(negedge clk);
        rst = 1'b0;

`ifdef REG_WB_INIT_EN
        for (int i = 0; i < NREGS + 1; i++) step(1'b0, '0, '0, AW'(i), acc);
`endif
        step(1'b0, '0, '0, '0, acc);

        // Single write with forwarding while in flight.
        step(1'b1, 5'd5, 32'hF000, 5'd5, acc);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 5'd5, acc);

        // Same register twice: youngest value must forward.
        step(1'b1, 5'd7, 32'h1, 5'd7, acc);
        step(1'b1, 5'd7, 32'h2, 5'd7, acc);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 5'd7, acc);

        // Register 0 is acknowledged but never written or forwarded.
        step(1'b1, 5'd0, 32'hDEAD, 5'd0, acc);
        check_val("reg0_ack", acc, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 5'd0, acc);

        // Back-to-back stream 1..6.
        for (int a = 1; a <= 6; a++) step(1'b1, AW'(a), DW'(a * 32'h111), AW'(a), acc);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 5'd3, acc);

        // Randomized traffic; an unaccepted request is held unchanged.
        hv = 1'b0;
        ha = '0;
        hd = '0;
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] fa;
            if (!hv) begin
                hv = ($urandom_range(0, 3) != 0);
                ha = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
                hd = $urandom;
            end
            fa = AW'($urandom_range(0, 7));
            step(hv, ha, hd, fa, acc);
            if (acc || !hv) hv = 1'b0;
        end

        // Reset in the middle of a stream.
        step(1'b1, 5'd9, 32'h9, 5'd9, acc);
        step(1'b1, 5'd10, 32'hA, 5'd10, acc);
        step(1'b1, 5'd11, 32'hB, 5'd11, acc);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_val("midrst_we3", we3, 1'b0);
        check_val("midrst_in_ready", in_ready, 1'b0);
        check_val("midrst_busy", busy, 1'b1);
        check_val("midrst_fwd_hit", fwd_hit, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREGS + 4; i++) step(1'b0, '0, '0, AW'(9 + (i % 3)), acc);
        step(1'b1, 5'd12, 32'hC, 5'd12, acc);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 5'd12, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
